// File: rtl/state_output_table.sv
`default_nettype none
// ============================================================================
//  Module      : state_output_table
//  Description : State register with sequential advance / jump, a runtime
//                writable per-state output-code table, and a registered,
//                enable-gated output code with a change pulse.
//
//  Ports
//    clk          rising-edge clock
//    rst          synchronous reset, active-high
//    en           output update enable (zip holds when low)
//    adv          advance state by one, modulo 2**STATE_W
//    jump_valid   load state from jump_state (wins over adv)
//    jump_state   jump target
//    tbl_we       table write strobe
//    tbl_addr     table entry to write
//    tbl_wdata    table write data
//    state        current state register
//    zip          registered output code
//    zip_changed  one-cycle pulse after zip took a new, different value
//
//  Revision    : 1.0  initial release
// ============================================================================
module state_output_table #(
    parameter int STATE_W     = 2,
    parameter int OUT_W       = 2,
    parameter int RESET_STATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               adv,
    input  logic               jump_valid,
    input  logic [STATE_W-1:0] jump_state,
    input  logic               tbl_we,
    input  logic [STATE_W-1:0] tbl_addr,
    input  logic [OUT_W-1:0]   tbl_wdata,
    output logic [STATE_W-1:0] state,
    output logic [OUT_W-1:0]   zip,
    output logic               zip_changed
);

    localparam int                 DEPTH         = 2 ** STATE_W;
    localparam logic [STATE_W-1:0] C_RESET_STATE = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] C_STATE_ONE   = STATE_W'(1);

    // ------------------------------------------------------------------------
    //  Registers
    // ------------------------------------------------------------------------
    logic [STATE_W-1:0]            r_state;
    logic [OUT_W-1:0]              r_zip;
    logic                          r_zip_changed;
    logic [DEPTH-1:0][OUT_W-1:0]   r_tbl;

    // ------------------------------------------------------------------------
    //  Combinational signals
    // ------------------------------------------------------------------------
    logic [STATE_W-1:0]            w_state_nxt;
    logic [OUT_W-1:0]              w_tbl_rd;
    logic [OUT_W-1:0]              w_eff;
    logic [OUT_W-1:0]              w_zip_nxt;
    logic                          w_zip_changed_nxt;
    logic [DEPTH-1:0][OUT_W-1:0]   w_tbl_init;

    // Default table contents: entry 1 decodes to all-ones, everything else to
    // zero. This is the legacy 2-bit decode (S1 -> 11) widened to any size.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tbl_init
            if (gi == 1) begin : g_ones
                assign w_tbl_init[gi] = {OUT_W{1'b1}};
            end else begin : g_zero
                assign w_tbl_init[gi] = {OUT_W{1'b0}};
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    //  State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    //  Next-state logic: jump has priority over advance; the increment wraps
    //  naturally by truncation to STATE_W bits.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (jump_valid) begin
            w_state_nxt = jump_state;
        end else if (adv) begin
            w_state_nxt = r_state + C_STATE_ONE;
        end
    end

    // ------------------------------------------------------------------------
    //  Output table. A write coinciding with reset is dropped because the
    //  reset branch reloads the whole table.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tbl <= w_tbl_init;
        end else if (tbl_we) begin
            r_tbl[tbl_addr] <= tbl_wdata;
        end
    end

    // ------------------------------------------------------------------------
    //  Output lookup / next-output logic. The lookup always uses the pre-edge
    //  state; a same-cycle write to that entry is forwarded so the new code
    //  shows up in zip at the write edge rather than one cycle later.
    // ------------------------------------------------------------------------
    always_comb begin
        w_tbl_rd          = r_tbl[r_state];
        w_eff             = w_tbl_rd;
        if (tbl_we && (tbl_addr == r_state)) begin
            w_eff = tbl_wdata;
        end
        w_zip_nxt         = r_zip;
        w_zip_changed_nxt = 1'b0;
        if (en) begin
            w_zip_nxt         = w_eff;
            w_zip_changed_nxt = (w_eff != r_zip);
        end
    end

    // ------------------------------------------------------------------------
    //  Output register (edge-triggered replacement for the old latch)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zip         <= {OUT_W{1'b0}};
            r_zip_changed <= 1'b0;
        end else begin
            r_zip         <= w_zip_nxt;
            r_zip_changed <= w_zip_changed_nxt;
        end
    end

    assign state       = r_state;
    assign zip         = r_zip;
    assign zip_changed = r_zip_changed;

endmodule
`default_nettype wire

// File: tb/tb_state_output_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_output_table
//  Description : Directed testbench for state_output_table (STATE_W=2,
//                OUT_W=2, RESET_STATE=0) with hand-computed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_state_output_table;

    logic       clk;
    logic       rst;
    logic       en;
    logic       adv;
    logic       jump_valid;
    logic [1:0] jump_state;
    logic       tbl_we;
    logic [1:0] tbl_addr;
    logic [1:0] tbl_wdata;
    logic [1:0] state;
    logic [1:0] zip;
    logic       zip_changed;

    int errors = 0;
    int checks = 0;

    state_output_table #(
        .STATE_W    (2),
        .OUT_W      (2),
        .RESET_STATE(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .adv        (adv),
        .jump_valid (jump_valid),
        .jump_state (jump_state),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .state      (state),
        .zip        (zip),
        .zip_changed(zip_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled and inputs changed 1 time
    // unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks state, zip and zip_changed together.
    task automatic chk3(input string tag, input logic [1:0] s, input logic [1:0] z,
                        input logic c);
        check({tag, ".state"}, {6'd0, state}, {6'd0, s});
        check({tag, ".zip"}, {6'd0, zip}, {6'd0, z});
        check({tag, ".chg"}, {7'd0, zip_changed}, {7'd0, c});
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        adv        = 1'b0;
        jump_valid = 1'b0;
        jump_state = 2'd0;
        tbl_we     = 1'b0;
        tbl_addr   = 2'd0;
        tbl_wdata  = 2'd0;

        // Reset and hold
        step();
        step();
        chk3("reset", 2'd0, 2'b00, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        step();
        chk3("hold1", 2'd0, 2'b00, 1'b0);
        step();
        chk3("hold2", 2'd0, 2'b00, 1'b0);

        // Default decode sweep: zip trails state by one edge
        adv = 1'b1;
        step(); chk3("sweep1", 2'd1, 2'b00, 1'b0);
        step(); chk3("sweep2", 2'd2, 2'b11, 1'b1);
        step(); chk3("sweep3", 2'd3, 2'b00, 1'b1);
        step(); chk3("wrap",   2'd0, 2'b00, 1'b0);

        // Jump beats advance
        jump_valid = 1'b1;
        jump_state = 2'd2;
        step(); chk3("jump_prio", 2'd2, 2'b00, 1'b0);
        jump_valid = 1'b0;
        adv        = 1'b0;

        // Write bypass into the current state's entry
        tbl_we    = 1'b1;
        tbl_addr  = 2'd2;
        tbl_wdata = 2'b10;
        step(); chk3("bypass", 2'd2, 2'b10, 1'b1);
        tbl_we = 1'b0;
        step(); chk3("bypass_hold", 2'd2, 2'b10, 1'b0);

        // Go to state 1 (zip still shows entry 2), then pick up 11
        jump_valid = 1'b1;
        jump_state = 2'd1;
        step(); chk3("to_s1", 2'd1, 2'b10, 1'b0);
        jump_valid = 1'b0;
        step(); chk3("s1_out", 2'd1, 2'b11, 1'b1);

        // Enable hold while advancing through 2 and 3
        en  = 1'b0;
        adv = 1'b1;
        step(); chk3("en_off_s2", 2'd2, 2'b11, 1'b0);
        step(); chk3("en_off_s3", 2'd3, 2'b11, 1'b0);
        adv = 1'b0;
        en  = 1'b1;
        step(); chk3("reenable", 2'd3, 2'b00, 1'b1);
        step(); chk3("unchanged", 2'd3, 2'b00, 1'b0);

        // Revisit state 2: written value persists
        jump_valid = 1'b1;
        jump_state = 2'd2;
        step(); chk3("revisit_jump", 2'd2, 2'b00, 1'b0);
        jump_valid = 1'b0;
        step(); chk3("revisit_s2", 2'd2, 2'b10, 1'b1);

        // Further table writes (not to the current entry), then go to 3
        tbl_we    = 1'b1;
        tbl_addr  = 2'd1;
        tbl_wdata = 2'b01;
        step(); chk3("wr1", 2'd2, 2'b10, 1'b0);
        tbl_addr  = 2'd0;
        tbl_wdata = 2'b10;
        jump_valid = 1'b1;
        jump_state = 2'd3;
        step(); chk3("wr0_jump3", 2'd3, 2'b10, 1'b0);
        jump_valid = 1'b0;

        // Reset mid-operation with a simultaneous write, adv and en
        rst       = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = 2'd0;
        tbl_wdata = 2'b01;
        adv       = 1'b1;
        en        = 1'b1;
        step(); chk3("mid_reset", 2'd0, 2'b00, 1'b0);
        rst    = 1'b0;
        tbl_we = 1'b0;

        // Table must be back to default; the reset-cycle write is gone
        step(); chk3("post_rst1", 2'd1, 2'b00, 1'b0);
        step(); chk3("post_rst2", 2'd2, 2'b11, 1'b1);
        step(); chk3("post_rst3", 2'd3, 2'b00, 1'b1);
        adv = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
